// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the sequential binary-to-BCD
//                converter: FSM state encoding, nibble width, the
//                digit-adjust threshold and a helper that gives the minimum
//                decimal digit count for a given binary width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Width of one BCD digit.
    localparam int NIBBLE_W = 4;

    // A digit at or above this value would exceed 9 after doubling, so it
    // receives +3 before the shift.
    localparam logic [NIBBLE_W-1:0] ADJ_THRESH = 4'd5;

    // Converter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // ceil(bin_w * log10(2)), with log10(2) approximated as 0.30103.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Combinational double-dabble digit correction. Adds 3 to a
//                BCD digit that is 5 or greater so that the following
//                left shift carries correctly into the next digit.
//  Ports       : i_digit  - scratch digit before correction
//                o_digit  - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_digit,
    output logic [NIBBLE_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential shift-and-add-3 (double dabble) binary-to-BCD
//                converter, one operand bit per clock. The result register
//                is updated only at the end of a conversion, so partial
//                scratch values are never visible on BCD.
//  Ports       : CLK    - clock, rising edge
//                RESET  - synchronous active-high reset
//                START  - conversion request (sampled only while idle)
//                BIN    - binary operand, sampled on an accepted START
//                BUSY   - high while a conversion is in progress
//                DONE   - one-cycle pulse when BCD is updated
//                BCD    - result, digit k in bits [4k+3:4k]
//                NEG    - sign of the last result (signed build only)
//  Options     : BIN_TO_BCD_SIGNED_EN - treat BIN as two's complement,
//                convert its magnitude and report the sign on NEG.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic [BIN_W-1:0]           BIN,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [NIBBLE_W*DIGITS-1:0] BCD
`ifdef BIN_TO_BCD_SIGNED_EN
    ,
    output logic                       NEG
`endif
);

    localparam int SCR_W = NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Refuse to build a converter whose result cannot hold the largest input.
    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             r_state;
    logic [BIN_W-1:0]   r_op;
    logic [SCR_W-1:0]   r_scr;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCR_W-1:0]   r_bcd;
    logic               r_done;

    logic [SCR_W-1:0]   w_adj;
    logic [BIN_W-1:0]   w_operand;
    logic               w_last;

    // Per-digit +3 correction applied to the scratch register each shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (r_scr[k*NIBBLE_W +: NIBBLE_W]),
            .o_digit (w_adj[k*NIBBLE_W +: NIBBLE_W])
        );
    end

`ifdef BIN_TO_BCD_SIGNED_EN
    logic r_sign;
    logic r_neg;

    // Magnitude of a two's complement operand; the most negative value
    // negates to itself, which read as unsigned is exactly 2^(BIN_W-1).
    assign w_operand = BIN[BIN_W-1] ? ((~BIN) + BIN_W'(1)) : BIN;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && START) begin
                r_sign <= BIN[BIN_W-1];
            end
            if (r_state == ST_FINISH) begin
                r_neg <= r_sign;
            end
        end
    end

    assign NEG = r_neg;
`else
    assign w_operand = BIN;
`endif

    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_op    <= w_operand;
                        r_scr   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Corrected digits and operand move left as one register.
                    {r_scr, r_op} <= {w_adj, r_op} << 1;
                    r_cnt         <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_bcd   <= r_scr;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (r_state != ST_IDLE);
    assign DONE = r_done;
    assign BCD  = r_bcd;

endmodule

`default_nettype wire
